input_skew_buf: RTL and testbench

- Sits directly downstream of the input memory array (mem_arr) and its controller (input_mem_ctrl).
- Takes one SYS_ROW-wide read vector per cycle and delays lane r by r extra cycles. This produces the diagonal wavefront that the SYS_ROW x SYS_COL systolic array's left edge requires.
- Tracks stream boundaries so the array controller knows when the last skewed element has been issued.

---
 rtl/systolic_pkg.sv | 17 +
 rtl/skew_lane.sv | 28 ++
 rtl/input_skew_buf.sv | 122 ++++++++++++
 tb/tb_input_skew_buf.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array input path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;

  localparam int SYS_ROW_DEF    = 16;
  localparam int DATA_WIDTH_DEF = 16;

  typedef logic [DATA_WIDTH_DEF-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } skew_state_t;

endpackage

// File: rtl/skew_lane.sv
// Resettable shift register of DEPTH stages, WIDTH bits per stage.
// Latency: DEPTH cycles from d to q.
// Backpressure: none; shifts every cycle.
module skew_lane #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [0:DEPTH-1];

  // Shift one stage per cycle; reset empties the whole line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/input_skew_buf.sv
// Skews each read row so lane r lags by r cycles, forming the array's diagonal wavefront.
// Latency: lane r output r+1 cycles after input; lane SYS_ROW-1 after SYS_ROW cycles.
// Backpressure: none; every valid vector is accepted, bubbles propagate as zero data.
module input_skew_buf
  import systolic_pkg::*;
#(
  parameter int SYS_ROW    = SYS_ROW_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data   [0:SYS_ROW-1],
  output logic [DATA_WIDTH-1:0] out_data  [0:SYS_ROW-1],
  output logic [SYS_ROW-1:0]    out_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(SYS_ROW + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SYS_ROW);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  skew_state_t      state, next_state;
  logic [CNT_W-1:0] drain_cnt, next_cnt;
  logic             done_nxt;
  logic             vld_last;

  // in_last only counts when it qualifies a valid vector.
  assign vld_last = in_valid & in_last;

  for (genvar r = 0; r < SYS_ROW; r++) begin : g_lane
    if (r == SYS_ROW - 1) begin : g_tail
      // Deepest lane also carries the last flag so out_last lines up with its element.
      logic [DATA_WIDTH+1:0] lane_d, lane_q;
      assign lane_d = in_valid ? {vld_last, 1'b1, in_data[r]} : '0;
      skew_lane #(.DEPTH(r + 1), .WIDTH(DATA_WIDTH + 2)) u_lane (
        .clk (clk),
        .rst (rst),
        .d   (lane_d),
        .q   (lane_q)
      );
      assign out_valid[r] = lane_q[DATA_WIDTH];
      assign out_data[r]  = lane_q[DATA_WIDTH] ? lane_q[DATA_WIDTH-1:0] : '0;
      assign out_last     = lane_q[DATA_WIDTH+1] & lane_q[DATA_WIDTH];
    end else begin : g_body
      logic [DATA_WIDTH:0] lane_d, lane_q;
      assign lane_d = in_valid ? {1'b1, in_data[r]} : '0;
      skew_lane #(.DEPTH(r + 1), .WIDTH(DATA_WIDTH + 1)) u_lane (
        .clk (clk),
        .rst (rst),
        .d   (lane_d),
        .q   (lane_q)
      );
      assign out_valid[r] = lane_q[DATA_WIDTH];
      // Zero data on invalid slots so PEs accumulate nothing from bubbles.
      assign out_data[r]  = lane_q[DATA_WIDTH] ? lane_q[DATA_WIDTH-1:0] : '0;
    end
  end

  // State, drain counter and registered done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      drain_cnt <= next_cnt;
      done      <= done_nxt;
    end
  end

  // Next-state: a last vector arms a SYS_ROW-cycle drain; any new vector reopens the stream.
  always_comb begin
    next_state = state;
    next_cnt   = drain_cnt;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_last) begin
            next_state = DRAIN;
            next_cnt   = CNT_FULL;
          end else begin
            next_state = STREAM;
          end
        end
      end
      STREAM: begin
        if (vld_last) begin
          next_state = DRAIN;
          next_cnt   = CNT_FULL;
        end
      end
      DRAIN: begin
        if (in_valid) begin
          if (in_last) begin
            next_cnt = CNT_FULL;
          end else begin
            next_state = STREAM;
          end
        end else if (drain_cnt == CNT_ONE) begin
          next_state = IDLE;
          next_cnt   = '0;
          done_nxt   = 1'b1;
        end else begin
          next_cnt = drain_cnt - CNT_ONE;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_input_skew_buf.sv
// Self-checking bench for input_skew_buf: directed scenarios plus a random stream
// checked against a cycle-history reference model.
module tb_input_skew_buf;
  import systolic_pkg::*;

  localparam int N    = SYS_ROW_DEF;
  localparam int DW   = DATA_WIDTH_DEF;
  localparam int MAXC = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_last;
  data_t         in_data  [0:N-1];
  data_t         out_data [0:N-1];
  logic [N-1:0]  out_valid;
  logic          out_last;
  logic          busy;
  logic          done;

  input_skew_buf #(.SYS_ROW(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Input history since the last reset, indexed by cycle.
  bit    hv [MAXC];
  bit    hl [MAXC];
  data_t hd [MAXC][N];
  data_t drv [N];

  // Outputs observed mid-cycle for cycle obs_t.
  logic [N-1:0] obs_valid;
  data_t        obs_data [N];
  logic         obs_last, obs_busy, obs_done;
  int           obs_t;

  // Reference model: lane r at cycle t shows the vector taken at cycle t-r-1.
  function automatic bit m_vld(input int r, input int t);
    int c = t - r - 1;
    return (c >= 0) && hv[c];
  endfunction

  function automatic data_t m_dat(input int r, input int t);
    int c = t - r - 1;
    if (c >= 0 && hv[c]) return hd[c][r];
    return '0;
  endfunction

  function automatic bit m_last(input int t);
    int c = t - N;
    return (c >= 0) && hv[c] && hl[c];
  endfunction

  function automatic int m_recent(input int t);
    for (int c = t - 1; c >= 0; c--) if (hv[c]) return c;
    return -1;
  endfunction

  // Busy while a stream is open, or within N cycles of the most recent last vector.
  function automatic bit m_busy(input int t);
    int c = m_recent(t);
    if (c < 0) return 1'b0;
    return !hl[c] || (t - c <= N);
  endfunction

  // Done exactly N+1 cycles after a last vector with no valid input since.
  function automatic bit m_done(input int t);
    int c = m_recent(t);
    if (c < 0) return 1'b0;
    return hl[c] && (t - c == N + 1);
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c < MAXC; c++) begin
      hv[c] = 1'b0;
      hl[c] = 1'b0;
    end
  endtask

  // Drive one cycle of input, record it, and capture outputs for this cycle.
  task automatic tick(input bit v, input bit l);
    in_valid = v;
    in_last  = l;
    for (int r = 0; r < N; r++) in_data[r] = v ? drv[r] : data_t'($urandom);
    hv[cyc] = v;
    hl[cyc] = l;
    for (int r = 0; r < N; r++) hd[cyc][r] = drv[r];
    @(negedge clk);
    obs_valid = out_valid;
    for (int r = 0; r < N; r++) obs_data[r] = out_data[r];
    obs_last = out_last;
    obs_busy = busy;
    obs_done = done;
    obs_t    = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int r = 0; r < N; r++) in_data[r] = data_t'($urandom);
    repeat (2) begin
      @(negedge clk);
      total++; if (out_valid !== '0) begin bad++; $display("FAIL reset_valid got=%h want=0", out_valid); end
      for (int r = 0; r < N; r++) begin
        total++; if (out_data[r] !== '0) begin bad++; $display("FAIL reset_data lane=%0d got=%h want=0", r, out_data[r]); end
      end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", out_last); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0);
      total++; if (obs_valid !== '0) begin bad++; $display("FAIL post_reset_valid t=%0d got=%h want=0", obs_t, obs_valid); end
      total++; if (obs_data[N-1] !== '0) begin bad++; $display("FAIL post_reset_data t=%0d got=%h want=0", obs_t, obs_data[N-1]); end
      total++; if (obs_last !== 1'b0) begin bad++; $display("FAIL post_reset_last t=%0d got=%b want=0", obs_t, obs_last); end
      total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy t=%0d got=%b want=0", obs_t, obs_busy); end
      total++; if (obs_done !== 1'b0) begin bad++; $display("FAIL post_reset_done t=%0d got=%b want=0", obs_t, obs_done); end
    end
  endtask

  task automatic test_single();
    apply_reset();
    for (int k = 0; k < 21; k++) begin
      if (k == 0) begin
        for (int r = 0; r < N; r++) drv[r] = data_t'(r + 1);
        tick(1'b1, 1'b1);
      end else begin
        tick(1'b0, 1'b0);
      end
      for (int r = 0; r < N; r++) begin
        total++; if (obs_valid[r] !== (obs_t == r + 1)) begin bad++; $display("FAIL single_valid t=%0d lane=%0d got=%b", obs_t, r, obs_valid[r]); end
        total++; if (obs_data[r] !== ((obs_t == r + 1) ? data_t'(r + 1) : data_t'(0))) begin bad++; $display("FAIL single_data t=%0d lane=%0d got=%h", obs_t, r, obs_data[r]); end
      end
      total++; if (obs_last !== (obs_t == 16)) begin bad++; $display("FAIL single_last t=%0d got=%b", obs_t, obs_last); end
      total++; if (obs_busy !== (obs_t >= 1 && obs_t <= 16)) begin bad++; $display("FAIL single_busy t=%0d got=%b", obs_t, obs_busy); end
      total++; if (obs_done !== (obs_t == 17)) begin bad++; $display("FAIL single_done t=%0d got=%b", obs_t, obs_done); end
    end
  endtask

  task automatic test_burst();
    apply_reset();
    for (int k = 0; k < 27; k++) begin
      if (k < 8) begin
        for (int r = 0; r < N; r++) drv[r] = data_t'(k);
        tick(1'b1, k == 7);
      end else begin
        tick(1'b0, 1'b0);
      end
      for (int r = 0; r < N; r++) begin
        bit ev;
        ev = (obs_t >= r + 1) && (obs_t <= r + 8);
        total++; if (obs_valid[r] !== ev) begin bad++; $display("FAIL burst_valid t=%0d lane=%0d got=%b want=%b", obs_t, r, obs_valid[r], ev); end
        total++; if (obs_data[r] !== (ev ? data_t'(obs_t - r - 1) : data_t'(0))) begin bad++; $display("FAIL burst_data t=%0d lane=%0d got=%h", obs_t, r, obs_data[r]); end
      end
      total++; if (obs_last !== (obs_t == 23)) begin bad++; $display("FAIL burst_last t=%0d got=%b", obs_t, obs_last); end
      total++; if (obs_done !== (obs_t == 24)) begin bad++; $display("FAIL burst_done t=%0d got=%b", obs_t, obs_done); end
      total++; if (obs_busy !== (obs_t >= 1 && obs_t <= 23)) begin bad++; $display("FAIL burst_busy t=%0d got=%b", obs_t, obs_busy); end
    end
  endtask

  task automatic test_bubble();
    apply_reset();
    for (int k = 0; k < 22; k++) begin
      if (k == 0) begin
        for (int r = 0; r < N; r++) drv[r] = data_t'(5);
        tick(1'b1, 1'b0);
      end else if (k == 2) begin
        for (int r = 0; r < N; r++) drv[r] = data_t'(6);
        tick(1'b1, 1'b1);
      end else begin
        tick(1'b0, 1'b0);
      end
      for (int r = 0; r < N; r++) begin
        bit    ev;
        data_t ed;
        ev = (obs_t == r + 1) || (obs_t == r + 3);
        ed = (obs_t == r + 1) ? data_t'(5) : (obs_t == r + 3) ? data_t'(6) : data_t'(0);
        total++; if (obs_valid[r] !== ev) begin bad++; $display("FAIL bubble_valid t=%0d lane=%0d got=%b want=%b", obs_t, r, obs_valid[r], ev); end
        total++; if (obs_data[r] !== ed) begin bad++; $display("FAIL bubble_data t=%0d lane=%0d got=%h want=%h", obs_t, r, obs_data[r], ed); end
      end
      total++; if (obs_last !== (obs_t == 18)) begin bad++; $display("FAIL bubble_last t=%0d got=%b", obs_t, obs_last); end
      total++; if (obs_done !== (obs_t == 19)) begin bad++; $display("FAIL bubble_done t=%0d got=%b", obs_t, obs_done); end
    end
  endtask

  task automatic test_two_streams();
    int ndone;
    ndone = 0;
    apply_reset();
    for (int k = 0; k < 28; k++) begin
      for (int r = 0; r < N; r++) drv[r] = data_t'($urandom);
      if (k <= 3 || k == 5 || k == 6) tick(1'b1, (k == 3) || (k == 6));
      else tick(1'b0, 1'b0);
      if (obs_done === 1'b1) ndone++;
      for (int r = 0; r < N; r++) begin
        total++; if (obs_data[r] !== m_dat(r, obs_t)) begin bad++; $display("FAIL streams_data t=%0d lane=%0d got=%h want=%h", obs_t, r, obs_data[r], m_dat(r, obs_t)); end
      end
      total++; if (obs_last !== (obs_t == 19 || obs_t == 22)) begin bad++; $display("FAIL streams_last t=%0d got=%b", obs_t, obs_last); end
      total++; if (obs_done !== (obs_t == 23)) begin bad++; $display("FAIL streams_done t=%0d got=%b", obs_t, obs_done); end
      total++; if (obs_busy !== (obs_t >= 1 && obs_t <= 22)) begin bad++; $display("FAIL streams_busy t=%0d got=%b", obs_t, obs_busy); end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL streams_done_count got=%0d want=1", ndone); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 320; k++) begin
      bit v, l;
      v = (k < 300) && ($urandom_range(9) < 7);
      l = ($urandom_range(4) == 0);
      for (int r = 0; r < N; r++) drv[r] = data_t'($urandom);
      tick(v, l);
      for (int r = 0; r < N; r++) begin
        total++; if (obs_valid[r] !== m_vld(r, obs_t)) begin bad++; $display("FAIL rand_valid t=%0d lane=%0d got=%b want=%b", obs_t, r, obs_valid[r], m_vld(r, obs_t)); end
        total++; if (obs_data[r] !== m_dat(r, obs_t)) begin bad++; $display("FAIL rand_data t=%0d lane=%0d got=%h want=%h", obs_t, r, obs_data[r], m_dat(r, obs_t)); end
      end
      total++; if (obs_last !== m_last(obs_t)) begin bad++; $display("FAIL rand_last t=%0d got=%b want=%b", obs_t, obs_last, m_last(obs_t)); end
      total++; if (obs_busy !== m_busy(obs_t)) begin bad++; $display("FAIL rand_busy t=%0d got=%b want=%b", obs_t, obs_busy, m_busy(obs_t)); end
      total++; if (obs_done !== m_done(obs_t)) begin bad++; $display("FAIL rand_done t=%0d got=%b want=%b", obs_t, obs_done, m_done(obs_t)); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < N; r++) drv[r] = data_t'($urandom_range(65535, 1));
      tick(k < 4, k == 3);
    end
    total++; if (obs_busy !== 1'b1) begin bad++; $display("FAIL midrst_pre_busy got=%b want=1", obs_busy); end
    total++; if (obs_valid[3:0] !== 4'hF) begin bad++; $display("FAIL midrst_pre_valid got=%h want=f", obs_valid[3:0]); end
    // Cycle 5: pulse reset between clock edges and look before any edge.
    in_valid = 1'b0;
    in_last  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== '0) begin bad++; $display("FAIL midrst_valid got=%h want=0", out_valid); end
    total++; if (out_data[0] !== '0) begin bad++; $display("FAIL midrst_data got=%h want=0", out_data[0]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick(1'b0, 1'b0);
      total++; if (obs_valid !== '0) begin bad++; $display("FAIL midrst_after_valid k=%0d got=%h want=0", k, obs_valid); end
      total++; if (obs_last !== 1'b0) begin bad++; $display("FAIL midrst_after_last k=%0d got=%b want=0", k, obs_last); end
      total++; if (obs_done !== 1'b0) begin bad++; $display("FAIL midrst_after_done k=%0d got=%b want=0", k, obs_done); end
      total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL midrst_after_busy k=%0d got=%b want=0", k, obs_busy); end
    end
  endtask

  initial begin
    for (int r = 0; r < N; r++) begin
      drv[r]     = '0;
      in_data[r] = '0;
    end
    test_reset();
    test_single();
    test_burst();
    test_bubble();
    test_two_streams();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
